// File: rtl/dw_fifo_s1_df_wc.sv
// Single-clock FIFO with run-time programmable almost-empty/almost-full thresholds,
// a live word count and selectable show-ahead or registered read data.
module dw_fifo_s1_df_wc #(
  parameter int width    = 8,
  parameter int depth    = 8,
  parameter int err_mode = 0,
  parameter int rst_mode = 0,
  parameter int out_reg  = 0,
  localparam int cw      = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_n,
  input  logic             push_req_n,
  input  logic             pop_req_n,
  input  logic             diag_n,
  input  logic [cw-1:0]    ae_level,
  input  logic [cw-1:0]    af_level,
  input  logic [width-1:0] data_in,
  output logic             empty,
  output logic             almost_empty,
  output logic             half_full,
  output logic             almost_full,
  output logic             full,
  output logic [cw-1:0]    word_count,
  output logic             error,
  output logic [width-1:0] data_out
);

  localparam int pw = $clog2(depth);
  localparam logic [pw-1:0] ptr_last = pw'(depth - 1);
  localparam logic [cw-1:0] cnt_full = cw'(depth);
  localparam logic [cw-1:0] cnt_half = cw'((depth + 1) / 2);

  logic [width-1:0] mem [depth];
  logic [pw-1:0]    wr_ptr, rd_ptr;
  logic [cw-1:0]    count;
  logic             push, pop, is_empty, is_full;
  logic             do_push, do_pop, overflow, underflow;
  logic [cw:0]      af_sum;

  assign push      = !push_req_n;
  assign pop       = !pop_req_n;
  assign is_empty  = (count == '0);
  assign is_full   = (count == cnt_full);
  assign do_pop    = pop && !is_empty;
  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_push   = push && (!is_full || pop);
  assign overflow  = push && is_full && !pop;
  assign underflow = pop && is_empty;

  function automatic logic [pw-1:0] ptr_inc(input logic [pw-1:0] p);
    return (p == ptr_last) ? '0 : p + pw'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (!clr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + cw'(1);
      else if (do_pop && !do_push) count <= count - cw'(1);
    end
  end

  if (rst_mode == 0) begin : g_mem_rst
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < depth; i++) mem[i] <= '0;
      end else if (!clr_n) begin
        for (int i = 0; i < depth; i++) mem[i] <= '0;
      end else if (do_push) begin
        mem[wr_ptr] <= data_in;
      end
    end
  end else begin : g_mem_norst
    always_ff @(posedge clk) begin
      if (clr_n && do_push) mem[wr_ptr] <= data_in;
    end
  end

  if (err_mode == 0) begin : g_err_sticky
    // A fresh error outranks a diag clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    error <= 1'b0;
      else if (!clr_n)               error <= 1'b0;
      else if (overflow | underflow) error <= 1'b1;
      else if (!diag_n)              error <= 1'b0;
    end
  end else begin : g_err_pulse
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      error <= 1'b0;
      else if (!clr_n) error <= 1'b0;
      else             error <= overflow | underflow;
    end
  end

  if (out_reg == 0) begin : g_dout_comb
    assign data_out = mem[rd_ptr];
  end else begin : g_dout_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      data_out <= '0;
      else if (!clr_n) data_out <= '0;
      else if (do_pop) data_out <= mem[rd_ptr];
    end
  end

  // Headroom compare done as a sum so af_level > depth saturates naturally.
  assign af_sum       = {1'b0, count} + {1'b0, af_level};
  assign empty        = is_empty;
  assign full         = is_full;
  assign almost_empty = (count <= ae_level);
  assign half_full    = (count >= cnt_half);
  assign almost_full  = (af_sum >= {1'b0, cnt_full});
  assign word_count   = count;

endmodule

// File: tb/tb_dw_fifo_s1_df_wc.sv
// Bench for dw_fifo_s1_df_wc: two configurations share stimulus and are checked
// against a queue-based reference model.
module tb_dw_fifo_s1_df_wc;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n, clr_n, push_req_n, pop_req_n, diag_n;
  logic [CW-1:0]    ae_level, af_level;
  logic [WIDTH-1:0] data_in;

  logic             empty0, aempty0, hfull0, afull0, full0, err0;
  logic [CW-1:0]    wc0;
  logic [WIDTH-1:0] dout0;
  logic             empty1, aempty1, hfull1, afull1, full1, err1;
  logic [CW-1:0]    wc1;
  logic [WIDTH-1:0] dout1;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] q[$];
  bit               err_s, err_p, zeroed;
  logic [WIDTH-1:0] dreg;

  always #5 clk = ~clk;

  dw_fifo_s1_df_wc #(.width(WIDTH), .depth(DEPTH), .err_mode(0), .rst_mode(0), .out_reg(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .push_req_n(push_req_n), .pop_req_n(pop_req_n),
    .diag_n(diag_n), .ae_level(ae_level), .af_level(af_level), .data_in(data_in),
    .empty(empty0), .almost_empty(aempty0), .half_full(hfull0), .almost_full(afull0),
    .full(full0), .word_count(wc0), .error(err0), .data_out(dout0));

  dw_fifo_s1_df_wc #(.width(WIDTH), .depth(DEPTH), .err_mode(1), .rst_mode(1), .out_reg(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .push_req_n(push_req_n), .pop_req_n(pop_req_n),
    .diag_n(diag_n), .ae_level(ae_level), .af_level(af_level), .data_in(data_in),
    .empty(empty1), .almost_empty(aempty1), .half_full(hfull1), .almost_full(afull1),
    .full(full1), .word_count(wc1), .error(err1), .data_out(dout1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    err_s  = 0;
    err_p  = 0;
    dreg   = '0;
    zeroed = 1;
  endtask

  task automatic model_update(input bit push, input bit pop, input logic [WIDTH-1:0] din,
                              input bit clr, input bit diag);
    bit uf, ov;
    if (clr) begin
      model_reset();
      return;
    end
    uf = pop && (q.size() == 0);
    ov = push && (q.size() == DEPTH) && !pop;
    if (pop && q.size() > 0) dreg = q.pop_front();
    if (push && !ov) begin
      q.push_back(din);
      zeroed = 0;
    end
    if (ov || uf) err_s = 1;
    else if (diag) err_s = 0;
    err_p = ov || uf;
  endtask

  task automatic check_all();
    int n;
    bit e_ae, e_af, e_hf;
    n    = q.size();
    e_ae = (n <= int'(ae_level));
    e_af = (int'(af_level) >= DEPTH) ? 1'b1 : (n >= DEPTH - int'(af_level));
    e_hf = (n >= (DEPTH + 1) / 2);
    chk("count0", wc0, n);          chk("count1", wc1, n);
    chk("empty0", empty0, n == 0);  chk("empty1", empty1, n == 0);
    chk("full0", full0, n == DEPTH); chk("full1", full1, n == DEPTH);
    chk("half0", hfull0, e_hf);     chk("half1", hfull1, e_hf);
    chk("aempty0", aempty0, e_ae);  chk("aempty1", aempty1, e_ae);
    chk("afull0", afull0, e_af);    chk("afull1", afull1, e_af);
    chk("err_sticky", err0, err_s);
    chk("err_pulse", err1, err_p);
    if (n > 0) chk("dout_show", dout0, q[0]);
    else if (zeroed) chk("dout_show_zero", dout0, 0);
    chk("dout_reg", dout1, dreg);
  endtask

  task automatic cycle(input bit push, input bit pop, input logic [WIDTH-1:0] din,
                       input bit clr = 0, input bit diag = 0);
    push_req_n = !push;
    pop_req_n  = !pop;
    clr_n      = !clr;
    diag_n     = !diag;
    data_in    = din;
    @(posedge clk);
    model_update(push, pop, din, clr, diag);
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 0; clr_n = 1; push_req_n = 1; pop_req_n = 1; diag_n = 1;
    ae_level = CW'(2); af_level = CW'(9); data_in = '0;
    model_reset();
    #1 check_all();
    af_level = CW'(1);
    #1 check_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // basic ordering
    cycle(1, 0, 8'h11); cycle(1, 0, 8'h22); cycle(1, 0, 8'h33);
    repeat (3) cycle(0, 1, 8'h00);

    // fill, overflow, diag clear, contents unchanged
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, WIDTH'(8'h40 + i));
    cycle(1, 0, 8'hEE);
    cycle(0, 0, 8'h00);
    cycle(0, 0, 8'h00, 0, 1);

    // full push+pop, 0xAA comes out last
    cycle(1, 1, 8'hAA);
    repeat (DEPTH) cycle(0, 1, 8'h00);

    // dynamic thresholds
    ae_level = CW'(2); af_level = CW'(1);
    cycle(1, 0, 8'h01); cycle(1, 0, 8'h02);
    ae_level = CW'(1);
    #1 check_all();
    for (int i = 0; i < 5; i++) cycle(1, 0, WIDTH'(i + 3));
    af_level = CW'(0);
    #1 check_all();

    // underflow behaviour
    cycle(0, 0, 8'h00, 1);
    cycle(0, 1, 8'h00); cycle(0, 1, 8'h00);
    cycle(0, 0, 8'h00); cycle(0, 0, 8'h00);
    cycle(1, 1, 8'h77);
    cycle(0, 0, 8'h00);

    // registered read, clear, async reset mid-burst
    cycle(0, 0, 8'h00, 1);
    cycle(1, 0, 8'h5C); cycle(0, 1, 8'h00);
    cycle(0, 0, 8'h00); cycle(0, 0, 8'h00);
    cycle(1, 0, 8'hA1); cycle(1, 1, 8'hA2); cycle(1, 0, 8'hA3); cycle(1, 0, 8'hA4);
    cycle(1, 1, 8'hB0, 1);
    cycle(1, 0, 8'hC1); cycle(1, 0, 8'hC2); cycle(0, 1, 8'h00);
    push_req_n = 0; data_in = 8'hC3;
    #3 rst_n = 0;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 check_all();
    rst_n = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = (i / 200) % 2 == 0 ? 65 : 35;
      if ($urandom_range(0, 19) == 0) ae_level = CW'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) af_level = CW'($urandom_range(0, 15));
      cycle($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias - 10,
            WIDTH'($urandom), $urandom_range(0, 99) < 2, $urandom_range(0, 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
